// File: rtl/hazard_controller_pkg.sv
// -----------------------------------------------------------------------------
// hazard_controller_pkg
// Shared pipeline definitions for the hazard controller: mult/div FSM state
// encoding, mult/div latency default, cycle-counter type and the
// source/destination register match helper.
// -----------------------------------------------------------------------------
package hazard_controller_pkg;

   // Cycles from MulDiv_Start until HI/LO are valid (legal range 2..63).
   localparam int MULDIV_CYCLES_DEFAULT = 32;

   // Wide enough to hold MULDIV_CYCLES-1 for the largest legal latency.
   localparam int MD_CNT_W = 6;
   typedef logic [MD_CNT_W-1:0] md_cnt_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } md_state_e;

   // A source depends on a destination only when it is really read and the
   // destination is not $zero (writes to $0 are discarded by the register file).
   function automatic logic reg_match(input logic       uses,
                                      input logic [4:0] src,
                                      input logic [4:0] dst);
      return uses && (src == dst) && (dst != 5'd0);
   endfunction

endpackage

// File: rtl/hazard_controller_muldiv_timer.sv
// -----------------------------------------------------------------------------
// muldiv_timer
// Two-state (IDLE/BUSY) FSM plus down-counter tracking one multi-cycle
// mult/div operation.
// Ports:
//   CLK, RESET   clock, asynchronous active-high reset
//   start_i      launch request; honoured only in IDLE
//   busy_o       1 exactly while the state is BUSY
//   done_o       1 on the last BUSY cycle (HI/LO valid)
// -----------------------------------------------------------------------------
module muldiv_timer
   import hazard_controller_pkg::*;
#(
   parameter int MULDIV_CYCLES = MULDIV_CYCLES_DEFAULT
) (
   input  logic CLK,
   input  logic RESET,
   input  logic start_i,
   output logic busy_o,
   output logic done_o
);

   localparam md_cnt_t CNT_LOAD = md_cnt_t'(MULDIV_CYCLES - 1);

   md_state_e state_q, state_d;
   md_cnt_t   cnt_q,   cnt_d;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_o  = 1'b0;
      done_o  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               cnt_d   = CNT_LOAD;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            busy_o = 1'b1;
            // Counter runs MULDIV_CYCLES-1 .. 0, giving MULDIV_CYCLES busy cycles.
            if (cnt_q == '0) begin
               done_o  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - md_cnt_t'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
// ID-stage hazard detection for a 5-stage MIPS pipeline: load-use, branch
// operand and mult/div (HI/LO) hazards, taken-branch squash, mult/div launch
// and a saturating stall-cycle counter.
// Ports:
//   CLK, RESET                    clock, asynchronous active-high reset
//   ID_*                          decoded info for the instruction in ID
//   ID_EX_*, EX_MEM_*             producer info from the EX and MEM stages
//   PC_Stall, IF_ID_Stall         hold PC and IF/ID
//   ID_EX_Flush                   bubble into ID/EX
//   IF_ID_Flush                   squash fetched instruction on taken branch
//   MulDiv_Start/Busy/Done        mult/div launch, in-progress, result valid
//   StallCount                    saturating count of stalled cycles
// -----------------------------------------------------------------------------
module hazard_controller
   import hazard_controller_pkg::*;
#(
   parameter int MULDIV_CYCLES = MULDIV_CYCLES_DEFAULT
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [4:0]  ID_RS,
   input  logic [4:0]  ID_RT,
   input  logic        ID_UsesRS,
   input  logic        ID_UsesRT,
   input  logic        ID_Branch,
   input  logic        ID_BranchTaken,
   input  logic        ID_IsMulDiv,
   input  logic        ID_ReadsHiLo,
   input  logic        ID_EX_MemRead,
   input  logic        ID_EX_RegWrite,
   input  logic [4:0]  ID_EX_WriteReg,
   input  logic        EX_MEM_MemRead,
   input  logic [4:0]  EX_MEM_WriteReg,
   output logic        PC_Stall,
   output logic        IF_ID_Stall,
   output logic        ID_EX_Flush,
   output logic        IF_ID_Flush,
   output logic        MulDiv_Start,
   output logic        MulDiv_Busy,
   output logic        MulDiv_Done,
   output logic [31:0] StallCount
);

   logic        match_ex, match_mem;
   logic        load_use_haz, branch_haz, muldiv_haz, stall;
   logic [31:0] stall_count_q, stall_count_d;

   assign match_ex  = reg_match(ID_UsesRS, ID_RS, ID_EX_WriteReg)
                    | reg_match(ID_UsesRT, ID_RT, ID_EX_WriteReg);
   assign match_mem = reg_match(ID_UsesRS, ID_RS, EX_MEM_WriteReg)
                    | reg_match(ID_UsesRT, ID_RT, EX_MEM_WriteReg);

   assign load_use_haz = ID_EX_MemRead & match_ex;
   // Branches compare in ID, so any EX result or a MEM load is still too late.
   assign branch_haz   = ID_Branch & ((ID_EX_RegWrite & match_ex)
                                    | (EX_MEM_MemRead & match_mem));
   assign muldiv_haz   = MulDiv_Busy & (ID_ReadsHiLo | ID_IsMulDiv);

   // One OR: coincident hazards cost a single stall cycle. Reset forces all
   // combinational outputs low regardless of the other inputs.
   assign stall = ~RESET & (load_use_haz | branch_haz | muldiv_haz);

   assign PC_Stall     = stall;
   assign IF_ID_Stall  = stall;
   assign ID_EX_Flush  = stall;
   // A stalled branch is re-evaluated next cycle, so it must not squash yet.
   assign IF_ID_Flush  = ~RESET & ID_BranchTaken & ~stall;
   assign MulDiv_Start = ~RESET & ~MulDiv_Busy & ID_IsMulDiv & ~stall;

   muldiv_timer #(
      .MULDIV_CYCLES (MULDIV_CYCLES)
   ) u_muldiv_timer (
      .CLK     (CLK),
      .RESET   (RESET),
      .start_i (MulDiv_Start),
      .busy_o  (MulDiv_Busy),
      .done_o  (MulDiv_Done)
   );

   always_comb begin
      stall_count_d = stall_count_q;
      if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
         stall_count_d = stall_count_q + 32'd1;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         stall_count_q <= '0;
      end else begin
         stall_count_q <= stall_count_d;
      end
   end

   assign StallCount = stall_count_q;

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have parameter MULDIV_CYCLES, default 32, giving the cycles from MulDiv_Start until HI/LO are valid; legal range 2..63.
REQ-002 SHALL have the following ports, clock and reset first:
- CLK  in  1  single clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- ID_RS, ID_RT  in  5  source register numbers of the instruction in ID.
- ID_UsesRS, ID_UsesRT  in  1  the ID instruction reads that source.
- ID_Branch  in  1  branch resolved in ID; needs final operands this cycle.
- ID_BranchTaken  in  1  branch-taken decision from ID compare.
- ID_IsMulDiv  in  1  the ID instruction is mult/div.
- ID_ReadsHiLo  in  1  the ID instruction is mfhi/mflo.
- ID_EX_MemRead, ID_EX_RegWrite  in  1  EX-stage instruction type.
- ID_EX_WriteReg  in  5  EX-stage destination register.
- EX_MEM_MemRead  in  1  MEM-stage instruction is a load.
- EX_MEM_WriteReg  in  5  MEM-stage destination register.
- PC_Stall, IF_ID_Stall  out  1  hold the PC and the IF/ID register.
- ID_EX_Flush  out  1  insert a bubble into ID/EX.
- IF_ID_Flush  out  1  squash the fetched instruction (taken branch).
- MulDiv_Start  out  1  one-cycle launch pulse to the mult/div unit.
- MulDiv_Busy  out  1  mult/div in progress.
- MulDiv_Done  out  1  one-cycle pulse when HI/LO become valid.
- StallCount  out  32  saturating count of stalled cycles.

Function
REQ-003 A source SHALL match a destination only if its Uses bit is set, the register numbers are equal, and the destination is not 0.
REQ-004 Load-use hazard SHALL be: ID_EX_MemRead and a source matches ID_EX_WriteReg.
REQ-005 Branch hazard SHALL be: ID_Branch, and either (ID_EX_RegWrite and a match on ID_EX_WriteReg) or (EX_MEM_MemRead and a match on EX_MEM_WriteReg).
REQ-006 Mult/div hazard SHALL be: state BUSY and (ID_ReadsHiLo or ID_IsMulDiv).
REQ-007 Stall SHALL be the OR of REQ-004..006; it SHALL be combinational from the inputs and the current state.
REQ-008 When Stall=1, PC_Stall, IF_ID_Stall and ID_EX_Flush SHALL all be 1 in that same cycle; otherwise all three SHALL be 0.
REQ-009 IF_ID_Flush SHALL equal ID_BranchTaken and not Stall; a stalled branch is re-evaluated on the next cycle.
REQ-010 The FSM SHALL have exactly two states, IDLE and BUSY.
REQ-011 In IDLE, if ID_IsMulDiv=1 and Stall=0, the block SHALL:
- drive MulDiv_Start=1 combinationally;
- load the cycle counter with MULDIV_CYCLES-1;
- enter BUSY on the next edge.
REQ-012 In BUSY, the counter SHALL decrement each cycle.
REQ-013 When the counter is 0 in BUSY, MulDiv_Done SHALL be 1 that cycle, the state SHALL return to IDLE on the next edge, and the mult/div hazard SHALL clear on that cycle's following edge.
REQ-014 MulDiv_Busy SHALL be 1 exactly while the state is BUSY.
REQ-015 A mult/div in ID during BUSY SHALL stall until IDLE and then launch per REQ-011; there SHALL be no back-to-back overlap.
REQ-016 StallCount SHALL increment on every edge where Stall=1 and SHALL saturate at 32'hFFFFFFFF.
REQ-017 Simultaneous load-use and branch hazards SHALL produce a single stall, not an additional cycle.

Reset
REQ-018 While RESET is high, the block SHALL hold the state at IDLE, the counter at 0 and StallCount at 0, and all outputs SHALL be 0 regardless of the other inputs.
REQ-019 Assertion of RESET mid-BUSY SHALL abort the operation immediately, with no MulDiv_Done pulse.

Structure
REQ-020 The FSM state encoding and the MULDIV_CYCLES default SHALL reside in the shared pipeline package.
REQ-021 The counter and the IDLE/BUSY FSM SHALL be one sub-module, muldiv_timer; the hazard compares SHALL stay in the top level.

Verification
REQ-022 The bench SHALL cover, at minimum, the following directed scenarios:
- lw $8 in EX (ID_EX_MemRead=1, WriteReg=8), ID uses RS=8 -> exactly 1 cycle of PC_Stall, IF_ID_Stall and ID_EX_Flush, then all 0.
- WriteReg=0 with a load and RS=0 -> no stall.
- beq in ID with RT=9; add $9 in EX -> stall 1 cycle. Next cycle, lw $9 in MEM -> stall 1 more cycle; then ID_BranchTaken=1 gives IF_ID_Flush=1.
- mult in ID with MULDIV_CYCLES=32 -> MulDiv_Start pulse, MulDiv_Busy for 32 cycles, MulDiv_Done on the last BUSY cycle. An mfhi arriving 3 cycles after the start stalls until the state returns to IDLE.
- RESET asserted in the 10th BUSY cycle -> all outputs 0 asynchronously, no MulDiv_Done pulse, StallCount=0.
- StallCount forced near 32'hFFFFFFFE with 3 stall cycles -> ends at 32'hFFFFFFFF.
